ahb_slave_mem: RTL and testbench

// - AHB-Lite responder: word-organised SRAM slave sitting behind ahb_decoder.
// - Driven by one slave_sel_out bit; its ready/resp/rdata return through the read mux.
// - Supports byte/half/word reads and writes, programmable wait states and a two-cycle ERROR response.
// - Fills one 1 KB decoder slot.

---
 rtl/ahb_pkg.sv | 64 ++++++
 rtl/ahb_mem_array.sv | 34 +++
 rtl/ahb_slave_mem.sv | 161 ++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane helpers
// used by the decoder, the master and the SRAM slave.
package ahb_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    // Write payload held for read-after-write forwarding
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] data;
    } wr_fwd_t;

    function automatic logic [BE_W-1:0] byte_enable(input logic [2:0] size,
                                                    input logic [1:0] offset);
        case (size)
            HSIZE_BYTE: return 4'b0001 << offset;
            HSIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] offset);
        case (size)
            HSIZE_HALF: return offset[0];
            HSIZE_WORD: return |offset;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] merge_word(input logic [WORD_W-1:0] base,
                                                     input logic [WORD_W-1:0] wdata,
                                                     input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] res;
        for (int b = 0; b < int'(BE_W); b++) begin
            res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : base[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised SRAM: one byte-enabled write port and one synchronous
// read port returning the pre-write contents on a same-cycle collision.
module ahb_mem_array
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned IDX_W    = $clog2(MEM_DEPTH)
) (
    input  logic              ahb_clk_in,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge ahb_clk_in) begin
        if (wr_en) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM responder: accepts address phases, inserts wait states,
// returns two-cycle ERROR for illegal accesses and forwards in-flight writes.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned SLOT_WIDTH     = 10,
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned WAIT_STATES    = 0
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rst_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic                      ahb_write_in,
    input  logic [2:0]                ahb_size_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    input  logic                      ahb_ready_in,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned OFS_W = IDX_W + 2;
    localparam int unsigned CNT_W = 4;

    slave_state_e      state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OFS_W-1:0]  addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic              ready_q;
    logic              resp_q;
    logic              rd_zero_q;
    logic              fwd_q;
    wr_fwd_t           fwd_data_q;

    logic              accept;
    logic              take;
    logic              out_of_range;
    logic              addr_err;
    logic              rd_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic              fwd_hit;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_bits;

    // Address-phase qualification and access legality
    assign accept       = ahb_sel_in & ahb_ready_in & ahb_trans_in[1];
    assign take         = accept & ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));
    assign out_of_range = |(ahb_addr_in[SLOT_WIDTH-1:0] >> OFS_W);
    assign addr_err     = (ahb_size_in > HSIZE_WORD)
                        | misaligned(ahb_size_in, ahb_addr_in[1:0])
                        | out_of_range;

    // Commit happens on the edge that closes DATA; a concurrent reset aborts it
    assign mem_we  = (state_q == ST_DATA) & write_q & ~ahb_rst_in;
    assign mem_be  = byte_enable(size_q, addr_q[1:0]);
    assign rd_en   = take & ~addr_err & ~ahb_write_in;
    assign fwd_hit = rd_en & mem_we & (addr_q[OFS_W-1:2] == ahb_addr_in[OFS_W-1:2]);

    assign unused_bits = &{1'b0, ahb_addr_in[AHB_ADDR_WIDTH-1:SLOT_WIDTH], ahb_trans_in[0]};

    ahb_mem_array #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .ahb_clk_in (ahb_clk_in),
        .wr_en      (mem_we),
        .wr_be      (mem_be),
        .wr_idx     (addr_q[OFS_W-1:2]),
        .wr_data    (ahb_wdata_in),
        .rd_en      (rd_en),
        .rd_idx     (ahb_addr_in[OFS_W-1:2]),
        .rd_data    (mem_rdata)
    );

    // Transfer FSM with registered HREADYOUT/HRESP
    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            ready_q <= 1'b1;
            resp_q  <= HRESP_OKAY;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (take) begin
                        addr_q  <= ahb_addr_in[OFS_W-1:0];
                        write_q <= ahb_write_in;
                        size_q  <= ahb_size_in;
                        if (addr_err) begin
                            state_q <= ST_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES - 1);
                            ready_q <= 1'b0;
                            resp_q  <= HRESP_OKAY;
                        end else begin
                            state_q <= ST_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= HRESP_OKAY;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_ERROR;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    resp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Read-data qualifiers: zero for reset/errors/writes, merge for forwarded writes
    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            rd_zero_q  <= 1'b1;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else if (take) begin
            rd_zero_q <= ~rd_en;
            fwd_q     <= fwd_hit;
            if (fwd_hit) begin
                fwd_data_q <= '{be: mem_be, data: ahb_wdata_in};
            end
        end
    end

    assign ahb_readyout_out = ready_q;
    assign ahb_resp_out     = resp_q;
    assign ahb_rdata_out    = rd_zero_q ? '0
                            : fwd_q     ? merge_word(mem_rdata, fwd_data_q.data, fwd_data_q.be)
                            :             mem_rdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed scoreboard bench for ahb_slave_mem in three wait-state/depth configurations.
module tb_ahb_slave_mem;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic        err;
    } tx_t;

    typedef struct {
        logic [31:0] rdata;
        logic        resp;
        int          waits;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [2:0]  ready;
    logic [2:0]  resp;
    logic [31:0] rdata [3];

    int    n_vec  = 0;
    int    n_miss = 0;
    int    ws_of [3];
    tx_t   txq [$];
    string txtag [$];
    exp_t  sb [$];
    string sbtag [$];

    always #5 clk = ~clk;

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[0]), .ahb_addr_in(addr),
        .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size), .ahb_wdata_in(wdata),
        .ahb_ready_in(ready[0]), .ahb_readyout_out(ready[0]), .ahb_resp_out(resp[0]),
        .ahb_rdata_out(rdata[0]));

    ahb_slave_mem #(.MEM_DEPTH(128), .WAIT_STATES(3)) u_ws3 (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[1]), .ahb_addr_in(addr),
        .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size), .ahb_wdata_in(wdata),
        .ahb_ready_in(ready[1]), .ahb_readyout_out(ready[1]), .ahb_resp_out(resp[1]),
        .ahb_rdata_out(rdata[1]));

    ahb_slave_mem #(.MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[2]), .ahb_addr_in(addr),
        .ahb_trans_in(trans), .ahb_write_in(write), .ahb_size_in(size), .ahb_wdata_in(wdata),
        .ahb_ready_in(ready[2]), .ahb_readyout_out(ready[2]), .ahb_resp_out(resp[2]),
        .ahb_rdata_out(rdata[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // For reads, data holds the expected rdata; for writes, the HWDATA to drive
    task automatic add_tx(input string tag, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d, input logic err);
        tx_t t;
        t.wr = wr; t.addr = a; t.size = sz; t.data = d; t.err = err;
        txq.push_back(t);
        txtag.push_back(tag);
    endtask

    // Drive the queued transfers back-to-back, pipelining address and data phases
    task automatic run_burst(input int di);
        int          n, ai, guard, lowcnt;
        bit          dvalid;
        logic        lowresp, s_ready, s_resp;
        logic [31:0] s_rdata;
        tx_t         dtx;
        exp_t        e, ne;
        string       tg;
        n = txq.size(); ai = 0; guard = 0; lowcnt = 0; dvalid = 1'b0; lowresp = 1'b0;
        dtx.wr = 1'b0; dtx.data = '0;
        while ((ai < n || dvalid) && guard < 100) begin
            sel = '0;
            if (ai < n) begin
                sel[di] = 1'b1; trans = 2'b10;
                addr = txq[ai].addr; write = txq[ai].wr; size = txq[ai].size;
            end else begin
                trans = 2'b00;
            end
            wdata = (dvalid && dtx.wr) ? dtx.data : 32'h0BAD_F00D;
            @(negedge clk);
            s_ready = ready[di]; s_resp = resp[di]; s_rdata = rdata[di];
            if (dvalid && !s_ready) begin
                lowcnt++;
                lowresp = s_resp;
            end
            @(posedge clk); #1;
            if (s_ready) begin
                if (dvalid) begin
                    e  = sb.pop_front();
                    tg = sbtag.pop_front();
                    check({tg, ".resp"}, 32'(s_resp), 32'(e.resp));
                    check({tg, ".waits"}, 32'(lowcnt), 32'(e.waits));
                    if (e.waits > 0) check({tg, ".lowresp"}, 32'(lowresp), 32'(e.resp));
                    if (e.chk_rd) check({tg, ".rdata"}, s_rdata, e.rdata);
                end
                if (ai < n) begin
                    dtx       = txq[ai];
                    ne.resp   = dtx.err;
                    ne.waits  = dtx.err ? 1 : ws_of[di];
                    ne.chk_rd = dtx.err | ~dtx.wr;
                    ne.rdata  = (dtx.err || dtx.wr) ? 32'h0 : dtx.data;
                    sb.push_back(ne);
                    sbtag.push_back(txtag[ai]);
                    ai++;
                    dvalid = 1'b1; lowcnt = 0; lowresp = 1'b0;
                end else begin
                    dvalid = 1'b0;
                end
            end
            guard++;
        end
        check("burst.pending", 32'(n - ai + int'(dvalid)), 32'd0);
        sel = '0; trans = 2'b00;
        txq.delete(); txtag.delete(); sb.delete(); sbtag.delete();
    endtask

    task automatic idle(input int cycles);
        sel = '0; trans = 2'b00;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        ws_of[0] = 0; ws_of[1] = 3; ws_of[2] = 2;
        rst = 1'b1; sel = '0; trans = 2'b00; addr = '0; write = 1'b0; size = 3'd0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values on every instance
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d.ready", k), 32'(ready[k]), 32'd1);
            check($sformatf("rst%0d.resp", k), 32'(resp[k]), 32'd0);
            check($sformatf("rst%0d.rdata", k), rdata[k], 32'h0);
        end
        @(posedge clk); #1;

        // Zero-wait word write then separate read
        add_tx("w0", 1'b1, 32'h0, 3'd2, 32'h1122_3344, 1'b0);
        run_burst(0);
        idle(1);
        add_tx("r0", 1'b0, 32'h0, 3'd2, 32'h1122_3344, 1'b0);
        run_burst(0);
        idle(1);

        // Byte and halfword lanes
        add_tx("w4",  1'b1, 32'h4, 3'd2, 32'h0000_0000, 1'b0);
        add_tx("wb5", 1'b1, 32'h5, 3'd0, 32'hAAAA_AAAA, 1'b0);
        add_tx("r4a", 1'b0, 32'h4, 3'd2, 32'h0000_AA00, 1'b0);
        add_tx("wh6", 1'b1, 32'h6, 3'd1, 32'hBEEF_BEEF, 1'b0);
        add_tx("r4b", 1'b0, 32'h4, 3'd2, 32'hBEEF_AA00, 1'b0);
        run_burst(0);
        idle(2);

        // Error responses leave memory intact
        add_tx("e_w2",  1'b1, 32'h2, 3'd2, 32'hFFFF_FFFF, 1'b1);
        add_tx("e_sz3", 1'b1, 32'h0, 3'd3, 32'hFFFF_FFFF, 1'b1);
        add_tx("e_r2",  1'b0, 32'h2, 3'd2, 32'h0, 1'b1);
        add_tx("r0e",   1'b0, 32'h0, 3'd2, 32'h1122_3344, 1'b0);
        run_burst(0);
        idle(1);

        // Back-to-back write/read forwarding
        add_tx("wf10", 1'b1, 32'h10, 3'd2, 32'hCAFE_F00D, 1'b0);
        add_tx("rf10", 1'b0, 32'h10, 3'd2, 32'hCAFE_F00D, 1'b0);
        run_burst(0);
        idle(1);

        // Unselected and BUSY cycles are ignored
        sel = '0; trans = 2'b10; write = 1'b1; addr = 32'h4; size = 3'd2; wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("nosel.ready", 32'(ready[0]), 32'd1);
            check("nosel.resp", 32'(resp[0]), 32'd0);
            @(posedge clk); #1;
        end
        sel[0] = 1'b1; trans = 2'b01;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("busy.ready", 32'(ready[0]), 32'd1);
            check("busy.resp", 32'(resp[0]), 32'd0);
            @(posedge clk); #1;
        end
        idle(1);
        add_tx("r4c", 1'b0, 32'h4, 3'd2, 32'hBEEF_AA00, 1'b0);
        add_tx("r0c", 1'b0, 32'h0, 3'd2, 32'h1122_3344, 1'b0);
        run_burst(0);
        idle(1);

        // Three wait states and out-of-range error on the 128-word instance
        add_tx("w8",   1'b1, 32'h8,   3'd2, 32'h1234_5678, 1'b0);
        add_tx("r8",   1'b0, 32'h8,   3'd2, 32'h1234_5678, 1'b0);
        add_tx("e3fc", 1'b0, 32'h3FC, 3'd2, 32'h0, 1'b1);
        add_tx("r8b",  1'b0, 32'h8,   3'd2, 32'h1234_5678, 1'b0);
        run_burst(1);
        idle(1);

        // Reset during the first wait of a write aborts it
        add_tx("w20", 1'b1, 32'h20, 3'd2, 32'h5A5A_5A5A, 1'b0);
        add_tx("r20", 1'b0, 32'h20, 3'd2, 32'h5A5A_5A5A, 1'b0);
        run_burst(2);
        idle(1);
        sel[2] = 1'b1; trans = 2'b10; write = 1'b1; addr = 32'h20; size = 3'd2;
        @(negedge clk);
        check("rstx.acc_ready", 32'(ready[2]), 32'd1);
        @(posedge clk); #1;
        sel = '0; trans = 2'b00; wdata = 32'hFFFF_FFFF; rst = 1'b1;
        @(negedge clk);
        check("rstx.wait_ready", 32'(ready[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstx.ready", 32'(ready[2]), 32'd1);
        check("rstx.resp", 32'(resp[2]), 32'd0);
        check("rstx.rdata", rdata[2], 32'h0);
        @(posedge clk); #1;
        add_tx("r20b", 1'b0, 32'h20, 3'd2, 32'h5A5A_5A5A, 1'b0);
        run_burst(2);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
